// File: rtl/div_sched_x4x2_if.sv
// div_sched_x4x2_if: request/response bus between requesters and the shared divider.
//   req_valid/req_data/req_ready : per-requester dividend handshake
//   resp_valid/resp_data/resp_err/resp_ready : quotient return handshake
interface div_sched_x4x2_if #(
    parameter int N    = 64,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic [N-1:0]      resp_data;
    logic              resp_err;
    logic              resp_ready;
    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/div_sched_x4x2.sv
// div_sched_x4x2: round-robin shared iterative GF(2)[x] divider by (x^4 + x^2).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of div_sched_x4x2_if (requests in, quotient out)
//   busy     : high while dividing or holding a response
module div_sched_x4x2 #(
    parameter int N    = 64,
    parameter int NREQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    div_sched_x4x2_if.slave    bus,
    output logic               busy
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int KW = $clog2(N / 2) > 0 ? $clog2(N / 2) : 1;
    typedef enum logic [1:0] {IDLE, ITER, RESP} state_t;
    state_t state, state_n;
    logic [PW-1:0] ptr, owner, win, idx;
    logic [N-1:0] src, q, wdata;
    logic [KW-1:0] k;
    logic err, found;
    // first requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    assign wdata = bus.req_data[int'(win)*N +: N];
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (found ? ITER : IDLE)
                : state == ITER ? (k == KW'(N/2 - 1) ? RESP : ITER)
                : (bus.resp_ready ? IDLE : RESP);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // q accumulates p' << 2k: one shifted copy of the dividend per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            owner <= '0;
            src   <= '0;
            q     <= '0;
            k     <= '0;
            err   <= 1'b0;
        end else if (state == IDLE && found) begin
            src   <= wdata >> 2;
            q     <= '0;
            k     <= '0;
            err   <= |wdata[1:0];
            owner <= win;
            ptr   <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
        end else if (state == ITER) begin
            q   <= q ^ src;
            src <= src << 2;
            k   <= k + 1'b1;
        end
    end
    assign bus.req_ready  = (state == IDLE && found) ? NREQ'(1) << win : '0;
    assign bus.resp_valid = state == RESP ? NREQ'(1) << owner : '0;
    assign bus.resp_data  = q;
    assign bus.resp_err   = err;
    assign busy           = state != IDLE;
endmodule

// File: tb/tb_div_sched_x4x2.sv
// tb_div_sched_x4x2: scoreboard bench for the shared divider scheduler.
module tb_div_sched_x4x2;
    localparam int N = 8;
    localparam int NREQ = 4;
    typedef struct {
        int         own;
        logic [7:0] d;
        logic       e;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    int errors = 0, checks = 0, cyc = 0, gcount = 0, g_edge = 0, last_acc = -1;
    bit b2b_chk = 0;
    exp_t sb[$];
    int glog[$];
    logic prv_rv = 1'b0, prv_rr = 1'b0, prv_err = 1'b0;
    logic [NREQ-1:0] prv_v = '0;
    logic [N-1:0] prv_d = '0;
    div_sched_x4x2_if #(.N(N), .NREQ(NREQ)) bus ();
    div_sched_x4x2 #(.N(N), .NREQ(NREQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] model(input logic [7:0] p);
        logic [7:0] s, r;
        s = p >> 2;
        r = '0;
        for (int j = 0; j < N / 2; j++) r = r ^ (s << (2 * j));
        return r;
    endfunction
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prv_rv = 1'b0;
        end else begin
            if (busy) chk("ready_while_busy", int'(bus.req_ready), 0);
            if (|(bus.req_valid & bus.req_ready)) begin
                exp_t e;
                chk("grant_onehot", $countones(bus.req_ready), 1);
                chk("grant_subset", int'(bus.req_ready & ~bus.req_valid), 0);
                for (int i = 0; i < NREQ; i++)
                    if (bus.req_ready[i]) begin
                        e.own = i;
                        e.d   = model(bus.req_data[i*N +: N]);
                        e.e   = |bus.req_data[i*N +: 2];
                        sb.push_back(e);
                        glog.push_back(i);
                    end
                gcount++;
                g_edge = cyc + 1;
                if (b2b_chk && last_acc >= 0) chk("grant_gap", g_edge - last_acc, 1);
            end
            if (|bus.resp_valid && !prv_rv) chk("resp_latency", cyc - g_edge, N / 2);
            if (prv_rv && !prv_rr) begin
                chk("hold_valid", int'(bus.resp_valid), int'(prv_v));
                chk("hold_data", int'(bus.resp_data), int'(prv_d));
                chk("hold_err", int'(bus.resp_err), int'(prv_err));
            end
            if (|bus.resp_valid && bus.resp_ready) begin
                if (sb.size() == 0) chk("unexpected_resp", int'(bus.resp_valid), 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_owner", int'(bus.resp_valid), 1 << e.own);
                    chk("resp_data", int'(bus.resp_data), int'(e.d));
                    chk("resp_err", int'(bus.resp_err), int'(e.e));
                end
                last_acc = cyc + 1;
            end
            prv_rv  = |bus.resp_valid;
            prv_rr  = bus.resp_ready;
            prv_v   = bus.resp_valid;
            prv_d   = bus.resp_data;
            prv_err = bus.resp_err;
        end
    end
    task automatic request(input int i, input logic [7:0] p);
        int t;
        t = 0;
        bus.req_data[i*N +: N] = p;
        bus.req_valid[i] = 1'b1;
        #1;
        while (!bus.req_ready[i] && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        if (t >= 200) chk("tmo_grant", 1, 0);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask
    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while ((busy || sb.size() != 0) && t < 200);
        if (t >= 200) chk("tmo_idle", 1, 0);
    endtask
    task automatic wait_resp();
        int t;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (bus.resp_valid == '0 && t < 200);
        if (t >= 200) chk("tmo_resp", 1, 0);
    endtask
    task automatic wait_grants(input int target);
        int t;
        t = 0;
        while (gcount < target && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) chk("tmo_grants", 1, 0);
    endtask
    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_data", int'(bus.resp_data), 0);
        chk("rst_resp_err", int'(bus.resp_err), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        request(0, 8'h3C);
        wait_idle();
        last_acc = -1;
        b2b_chk = 1;
        bus.req_data[1*N +: N] = 8'h14;
        bus.req_valid[1] = 1'b1;
        wait_grants(gcount + 2);
        bus.req_valid[1] = 1'b0;
        wait_idle();
        b2b_chk = 0;
        rst = 1'b1;
        bus.req_data = {8'h28, 8'h3D, 8'h14, 8'h3C};
        bus.req_valid = '1;
        glog.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        wait_grants(gcount + 5);
        bus.req_valid = '0;
        wait_idle();
        chk("rr_count", glog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            chk($sformatf("rr_order%0d", i), glog[i], i % NREQ);
        bus.resp_ready = 1'b0;
        last_acc = -1;
        b2b_chk = 1;
        request(2, 8'hA0);
        wait_resp();
        bus.req_data[3*N +: N] = 8'h3C;
        bus.req_valid[3] = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        wait_grants(gcount + 1);
        bus.req_valid[3] = 1'b0;
        wait_idle();
        b2b_chk = 0;
        request(0, 8'h3D);
        wait_idle();
        request(1, 8'h3C);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_resp_valid", int'(bus.resp_valid), 0);
        chk("abort_ptr", int'(dut.ptr), 0);
        repeat (20) @(posedge clk);
        #1 chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
